// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared data bus.
// One access is in flight at a time. The winner's command is latched and held
// on the bus for LATENCY cycles, the response is captured, and a single ack
// pulse is returned to the requester that won.
//
// state  | meaning
// IDLE   | bus quiet; sample requests and grant one
// ACCESS | latched command driven on the bus; latency counter running down
// RESP   | one-cycle ack to the granted requester with the captured response
module bus_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_ack,
  output logic [63:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_ack,
  output logic [63:0] m1_rdata,
  output logic        m1_err,
  output logic        bus_rw,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_write,
  input  logic [63:0] bus_read,
  input  logic        bus_exception,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        gnt, gnt_nxt;
  logic        last, last_nxt;
  logic        lat_rw, lat_rw_nxt;
  logic [63:0] lat_addr, lat_addr_nxt;
  logic [63:0] lat_wdata, lat_wdata_nxt;
  logic        capture;
  logic        any_req;
  logic        win;
  logic [63:0] rdata0, rdata1;
  logic        err0, err1;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) win = ~last;
    else                  win = m1_req;
  end

  // Next-state logic and command latching.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    last_nxt      = last;
    lat_rw_nxt    = lat_rw;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt     = ACCESS;
          gnt_nxt       = win;
          last_nxt      = win;
          cnt_nxt       = CNT_LOAD;
          lat_rw_nxt    = win ? m1_rw    : m0_rw;
          lat_addr_nxt  = win ? m1_addr  : m0_addr;
          lat_wdata_nxt = win ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched command and per-requester response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt       <= 1'b0;
      last      <= 1'b1;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      last      <= last_nxt;
      lat_rw    <= lat_rw_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      if (capture) begin
        if (gnt) begin
          rdata1 <= bus_read;
          err1   <= bus_exception;
        end else begin
          rdata0 <= bus_read;
          err0   <= bus_exception;
        end
      end
    end
  end

  // Bus is forced to zero outside ACCESS so a stale command can never strobe a write.
  always_comb begin
    busy      = (state != IDLE);
    bus_rw    = (state == ACCESS) ? lat_rw    : 1'b0;
    bus_addr  = (state == ACCESS) ? lat_addr  : '0;
    bus_write = (state == ACCESS) ? lat_wdata : '0;
    m0_ack    = (state == RESP) && !gnt;
    m1_ack    = (state == RESP) &&  gnt;
    m0_rdata  = rdata0;
    m1_rdata  = rdata1;
    m0_err    = err0;
    m1_err    = err1;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (LATENCY 1 and 3) share the same
// stimulus; a transaction-timing reference model predicts every output.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [63:0] bus_read;
  logic        bus_exception;

  logic        o_m0_ack [2];
  logic        o_m1_ack [2];
  logic [63:0] o_m0_rdata [2];
  logic [63:0] o_m1_rdata [2];
  logic        o_m0_err [2];
  logic        o_m1_err [2];
  logic        o_bus_rw [2];
  logic [63:0] o_bus_addr [2];
  logic [63:0] o_bus_write [2];
  logic        o_busy [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    bus_arbiter #(.LATENCY(k == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(o_m0_ack[k]), .m0_rdata(o_m0_rdata[k]), .m0_err(o_m0_err[k]),
      .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(o_m1_ack[k]), .m1_rdata(o_m1_rdata[k]), .m1_err(o_m1_err[k]),
      .bus_rw(o_bus_rw[k]), .bus_addr(o_bus_addr[k]), .bus_write(o_bus_write[k]),
      .bus_read(bus_read), .bus_exception(bus_exception), .busy(o_busy[k])
    );
  end

  // Reference model: an access accepted in cycle A occupies the bus in
  // cycles A+1..A+L, acks in A+L+1, and the arbiter is free again at A+L+2.
  int          acc [2];
  bit          last_g [2];
  bit          gnt_m [2];
  bit          lrw [2];
  logic [63:0] laddr [2];
  logic [63:0] lwd [2];
  logic [63:0] mrd [2][2];
  bit          merr [2][2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit in_access(input int k, input int c);
    return (c > acc[k]) && (c <= acc[k] + lat_of(k));
  endfunction

  function automatic bit in_resp(input int k, input int c);
    return c == acc[k] + lat_of(k) + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    acc[k]    = -1000;
    last_g[k] = 1'b1;
    gnt_m[k]  = 1'b0;
    for (int j = 0; j < 2; j++) begin
      mrd[k][j]  = '0;
      merr[k][j] = 1'b0;
    end
  endtask

  task automatic model_update(input int k);
    bit a, r, w;
    a = in_access(k, cyc);
    r = in_resp(k, cyc);
    if (rst) begin
      model_reset(k);
    end else begin
      if (a && cyc == acc[k] + lat_of(k)) begin
        mrd[k][gnt_m[k]]  = bus_read;
        merr[k][gnt_m[k]] = bus_exception;
      end
      if (!a && !r && (m0_req || m1_req)) begin
        if (m0_req && m1_req) w = !last_g[k];
        else                  w = m1_req;
        gnt_m[k]  = w;
        last_g[k] = w;
        acc[k]    = cyc;
        lrw[k]    = w ? m1_rw    : m0_rw;
        laddr[k]  = w ? m1_addr  : m0_addr;
        lwd[k]    = w ? m1_wdata : m0_wdata;
      end
    end
  endtask

  task automatic check_all(input int k);
    bit a, r;
    string p;
    a = in_access(k, cyc);
    r = in_resp(k, cyc);
    p = (k == 0) ? "L1" : "L3";
    chk({p, " busy"},      64'(o_busy[k]),      64'(a || r));
    chk({p, " bus_rw"},    64'(o_bus_rw[k]),    64'(a ? lrw[k] : 1'b0));
    chk({p, " bus_addr"},  o_bus_addr[k],       a ? laddr[k] : 64'd0);
    chk({p, " bus_write"}, o_bus_write[k],      a ? lwd[k]   : 64'd0);
    chk({p, " m0_ack"},    64'(o_m0_ack[k]),    64'(r && !gnt_m[k]));
    chk({p, " m1_ack"},    64'(o_m1_ack[k]),    64'(r &&  gnt_m[k]));
    chk({p, " two_acks"},  64'(o_m0_ack[k] & o_m1_ack[k]), 64'd0);
    chk({p, " m0_rdata"},  o_m0_rdata[k],       mrd[k][0]);
    chk({p, " m1_rdata"},  o_m1_rdata[k],       mrd[k][1]);
    chk({p, " m0_err"},    64'(o_m0_err[k]),    64'(merr[k][0]));
    chk({p, " m1_err"},    64'(o_m1_err[k]),    64'(merr[k][1]));
  endtask

  // Advance one clock: model consumes this cycle's inputs, then outputs are checked.
  task automatic tick();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    cyc++;
    check_all(0);
    check_all(1);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_wdata = '0;
    bus_read = '0; bus_exception = 1'b0;
    model_reset(0);
    model_reset(1);
    ticks(2);
    rst = 1'b0;
    ticks(1);

    // m0 read of 0x1000 returning 0x55
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 64'h1000; bus_read = 64'h55;
    tick();
    idle_inputs();
    ticks(6);

    // Tie from reset: both held, grants must alternate starting with m0
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 64'h2000; m1_addr = 64'h3000;
    m1_rw = 1'b1; m1_wdata = 64'h1234;
    for (int i = 0; i < 24; i++) begin
      bus_read = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
    ticks(6);

    // m1 write 0xAB to the LED register
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 64'hFFFF_0000; m1_wdata = 64'hAB;
    tick();
    idle_inputs();
    ticks(6);

    // m1 read with exception, then a clean one
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 64'h4000; bus_exception = 1'b1; bus_read = 64'hDEAD;
    tick();
    idle_inputs();
    ticks(5);
    bus_exception = 1'b0; bus_read = 64'hBEEF;
    m1_req = 1'b1;
    tick();
    idle_inputs();
    ticks(6);

    // Reset during ACCESS, then a tie must go to m0
    m1_req = 1'b1; m1_addr = 64'h5000;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    idle_inputs();
    ticks(6);

    // m0 drops req and changes addr mid-access
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 64'h6000; m0_wdata = 64'h77;
    tick();
    m0_req = 1'b0; m0_addr = 64'h9999; m0_wdata = 64'h88;
    ticks(6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      m0_req        = ($urandom_range(0, 2) != 0);
      m1_req        = ($urandom_range(0, 2) != 0);
      m0_rw         = $urandom_range(0, 1);
      m1_rw         = $urandom_range(0, 1);
      m0_addr       = {$urandom, $urandom};
      m1_addr       = {$urandom, $urandom};
      m0_wdata      = {$urandom, $urandom};
      m1_wdata      = {$urandom, $urandom};
      bus_read      = {$urandom, $urandom};
      bus_exception = $urandom_range(0, 1);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    ticks(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
